// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side blocks.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    localparam int DATA_BITS_DEFAULT = 8;

    // Round-robin successor of ptr over n requesters.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1) % n;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin winner select: first valid index at or above ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     winner,
    output logic               any
);

    logic [IDW-1:0] idx;

    // Scan from the farthest offset down so the nearest valid index is written last.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (valid[idx]) winner = idx;
        end
    end

    assign any = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants the shared UART transmitter to one source per message, round-robin,
// with a hold timeout that evicts a source stalling mid-message.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ     = 4,
    parameter int  DATA_BITS   = DATA_BITS_DEFAULT,
    parameter int  HOLD_CYCLES = 4096,
    localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int HCW         = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_start,
    output logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_done,
    output logic [IDW-1:0]               grant_id,
    output logic                         busy
);

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr, winner, next_ptr;
    logic           any, last_q, accept, hold_expired;
    logic [HCW-1:0] hold_cnt;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
        .valid  (req_valid),
        .ptr    (rr_ptr),
        .winner (winner),
        .any    (any)
    );

    assign accept       = (state == SEND) && req_valid[grant_id];
    assign hold_expired = (hold_cnt == HCW'(HOLD_CYCLES - 1));
    assign next_ptr     = IDW'(rr_next(int'(grant_id), NUM_REQ));
    assign busy         = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (state == SEND) req_ready[grant_id] = req_valid[grant_id];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // tx_done is only honoured after the tx_start cycle, so a stale pulse cannot end a byte.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any) state_nxt = SEND;
            SEND:    if (accept) state_nxt = WAIT;
                     else if (hold_expired) state_nxt = IDLE;
            WAIT:    if (tx_done && !tx_start) state_nxt = last_q ? IDLE : SEND;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            tx_data  <= '0;
            last_q   <= 1'b0;
            hold_cnt <= '0;
            tx_start <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    grant_id <= winner;
                    hold_cnt <= '0;
                end
                SEND: begin
                    if (accept) begin
                        tx_data  <= req_data[grant_id*DATA_BITS +: DATA_BITS];
                        last_q   <= req_last[grant_id];
                        tx_start <= 1'b1;
                    end else if (hold_expired) begin
                        rr_ptr <= next_ptr;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT: if (tx_done && !tx_start) begin
                    if (last_q) rr_ptr <= next_ptr;
                    else        hold_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: a 4-source instance with a short hold
// timeout, plus a 3-source instance for the non-power-of-two wrap.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int DB       = 8;
    localparam int HOLD     = 8;
    localparam int DONE_DLY = 10;

    typedef struct packed {
        logic [1:0]    src;
        logic [DB-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_last, req_ready;
    logic [N*DB-1:0]   req_data;
    logic              tx_start, tx_done, busy;
    logic [DB-1:0]     tx_data;
    logic [1:0]        grant_id;

    logic [2:0]        v3, l3, rdy3;
    logic [3*DB-1:0]   d3;
    logic              ts3, done3, busy3;
    logic [DB-1:0]     td3;
    logic [1:0]        gid3;

    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    bit   inflight;
    exp_t sb[$];
    logic [DB:0] src_q [N][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
        .tx_data(tx_data), .tx_done(tx_done), .grant_id(grant_id), .busy(busy)
    );

    uart_tx_arbiter #(.NUM_REQ(3), .DATA_BITS(DB), .HOLD_CYCLES(HOLD)) dut3 (
        .clk(clk), .reset(reset), .req_valid(v3), .req_data(d3),
        .req_last(l3), .req_ready(rdy3), .tx_start(ts3),
        .tx_data(td3), .tx_done(done3), .grant_id(gid3), .busy(busy3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic expect_byte(input int src, input logic [DB-1:0] data);
        exp_t e;
        e.src  = 2'(src);
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic offer(input int src, input logic last, input logic [DB-1:0] data);
        src_q[src].push_back({last, data});
    endtask

    // which: 0 tx_start, 1 tx_done, 10+i req_ready[i], 20+i req_valid[i]
    task automatic wait_sig(input int which, input string name);
        bit hit = 1'b0;
        for (int n = 0; n < 300 && !hit; n++) begin
            @(negedge clk); #2;
            if (which == 0)       hit = tx_start;
            else if (which == 1)  hit = tx_done;
            else if (which < 20)  hit = req_ready[which-10];
            else                  hit = req_valid[which-20];
        end
        if (!hit) timeout(name);
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            @(negedge clk); #2;
            ok = (sb.size() == 0) && !busy && !inflight && src_empty();
        end
        if (!ok) timeout(name);
    endtask

    // Source driver: each source presents its queue head; pop after a handshake edge.
    initial begin
        logic [N-1:0] hs;
        logic [DB:0]  h;
        hs = '0;
        req_valid = '0; req_last = '0; req_data = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    h = src_q[i][0];
                    req_valid[i]          = 1'b1;
                    req_last[i]           = h[DB];
                    req_data[i*DB +: DB]  = h[DB-1:0];
                end else begin
                    req_valid[i]          = 1'b0;
                    req_last[i]           = 1'b0;
                    req_data[i*DB +: DB]  = '0;
                end
            end
            #1 hs = req_valid & req_ready;
        end
    end

    // Transmitter model: tx_done DONE_DLY cycles after each tx_start.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat (DONE_DLY) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    // Monitor: pop expected byte at every tx_start, recheck data at tx_done.
    initial begin
        exp_t e, cur;
        inflight = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk); #3;
            if (!reset) inflight = 1'b0;
            if (tx_start) begin
                if (sb.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_tx_start: data %0h grant %0d, none expected", tx_data, grant_id);
                end else begin
                    e = sb.pop_front();
                    check("tx_data", tx_data, e.data);
                    check("grant_id", grant_id, e.src);
                    cur = e;
                    inflight = 1'b1;
                end
            end
            if (tx_done && inflight) begin
                check("tx_data_stable", tx_data, cur.data);
                inflight = 1'b0;
            end
            if (req_ready != '0) check("ready_onehot", $onehot(req_ready), 1);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, n;
        bit seen;
        reset = 1'b1;
        v3 = '0; l3 = '0; d3 = '0; done3 = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rr_ptr", dut.rr_ptr, 0);
        reset = 1'b1;

        // Round robin over 0,1,3 with two one-byte messages each.
        expect_byte(0, 8'h00); expect_byte(1, 8'h01); expect_byte(3, 8'h03);
        expect_byte(0, 8'h10); expect_byte(1, 8'h11); expect_byte(3, 8'h13);
        offer(0, 1, 8'h00); offer(1, 1, 8'h01); offer(3, 1, 8'h03);
        offer(0, 1, 8'h10); offer(1, 1, 8'h11); offer(3, 1, 8'h13);
        wait_drain("rr_drain");
        check("rr_ptr_after_rr", dut.rr_ptr, 0);

        // Single one-byte message from source 2.
        expect_byte(2, 8'h5A);
        offer(2, 1, 8'h5A);
        wait_sig(22, "single_valid");
        c0 = cyc;
        wait_sig(0, "single_start");
        check("req_to_start_latency", cyc - c0, 2);
        wait_drain("single_drain");
        check("single_grant_id", grant_id, 2);
        check("single_busy", busy, 0);
        check("single_rr_ptr", dut.rr_ptr, 3);

        // Atomic 3-byte message from source 1 while source 0 waits.
        expect_byte(1, 8'h11); expect_byte(1, 8'h22); expect_byte(1, 8'h33);
        expect_byte(0, 8'h0F);
        offer(1, 0, 8'h11); offer(1, 0, 8'h22); offer(1, 1, 8'h33);
        wait_sig(11, "atom_grant");
        offer(0, 1, 8'h0F);
        wait_sig(1, "atom_done");
        n = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk); #2;
            if (tx_start) begin seen = 1'b1; n = k; end
        end
        check("done_to_start_turnaround", n, 2);
        wait_drain("atom_drain");
        check("atom_rr_ptr", dut.rr_ptr, 1);

        // Hold timeout: source 0 stalls after its first byte, source 1 waits.
        expect_byte(0, 8'hA0); expect_byte(1, 8'hB1);
        offer(0, 0, 8'hA0);
        wait_sig(10, "hold_grant");
        offer(1, 1, 8'hB1);
        wait_sig(1, "hold_done");
        n = 0;
        seen = 1'b0;
        for (int k = 1; k <= 30 && !seen; k++) begin
            @(negedge clk); #2;
            if (!busy) begin seen = 1'b1; n = k; end
        end
        check("hold_release_cycles", n, HOLD + 1);
        check("hold_rr_ptr", dut.rr_ptr, 1);
        wait_drain("hold_drain");

        // Reset in WAIT right after tx_start.
        expect_byte(3, 8'hC3);
        offer(3, 1, 8'hC3);
        wait_sig(0, "rst_mid_start");
        #2 reset = 1'b0;
        #1;
        check("midrst_tx_start", tx_start, 0);
        check("midrst_busy", busy, 0);
        check("midrst_req_ready", req_ready, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #2;
            if (busy) seen = 1'b1;
        end
        check("late_done_no_grant", seen, 0);
        check("late_done_grant_id", grant_id, 0);
        check("late_done_rr_ptr", dut.rr_ptr, 0);

        // Three-source wrap: index 2 finishes, then 0 beats 2.
        v3 = 3'b100; d3 = {8'h72, 8'h00, 8'h00}; l3 = 3'b100;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk); #2;
            seen = rdy3[2];
        end
        if (!seen) timeout("n3_grant2");
        @(negedge clk); #2;
        check("n3_tx_start", ts3, 1);
        check("n3_tx_data", td3, 8'h72);
        check("n3_grant_id", gid3, 2);
        v3 = '0;
        done3 = 1'b1;
        @(negedge clk); #2;
        done3 = 1'b0;
        check("n3_done_in_start_ignored", busy3, 1);
        @(negedge clk); #2;
        done3 = 1'b1;
        @(negedge clk); #2;
        done3 = 1'b0;
        check("n3_idle", busy3, 0);
        check("n3_rr_ptr_wrap", dut3.rr_ptr, 0);
        v3 = 3'b101; d3 = {8'h72, 8'h00, 8'h70}; l3 = 3'b101;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk); #2;
            seen = (rdy3 != '0);
        end
        if (!seen) timeout("n3_contend");
        check("n3_contend_ready", rdy3, 3'b001);
        check("n3_contend_grant", gid3, 0);
        @(negedge clk); #2;
        v3 = '0;
        check("n3_contend_data", td3, 8'h70);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter in `Main` between several on-chip message sources. Each source offers bytes through a valid/ready handshake and marks the final byte of a message with `last`. The arbiter grants one source for a whole message using round-robin priority, hands each byte to the transmitter, and waits for the transmitter's completion pulse before taking the next byte. A hold timeout stops a stalled source from keeping the line.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `DATA_BITS`, default 8: byte width; matches the UART frame.
- `HOLD_CYCLES`, default 4096: number of idle `clk` cycles a granted source may go without offering a byte mid-message before it loses the grant.

Ports:
- `clk`, input, 1: system clock, the same clock that drives `BaudRateGenerator`.
- `reset`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, `NUM_REQ`: per-source byte offered.
- `req_data`, input, `NUM_REQ*DATA_BITS`: per-source byte; source i occupies bits `[i*DATA_BITS +: DATA_BITS]`.
- `req_last`, input, `NUM_REQ`: the offered byte ends the message.
- `req_ready`, output, `NUM_REQ`: byte accepted this cycle. One-hot or zero.
- `tx_start`, output, 1: one-cycle pulse telling the UART transmitter to send `tx_data`.
- `tx_data`, output, `DATA_BITS`: byte to transmit; stable from the `tx_start` cycle until `tx_done`.
- `tx_done`, input, 1: one-cycle pulse from the transmitter when the stop bit has completed.
- `grant_id`, output, `max(1,$clog2(NUM_REQ))`: index of the current or most recent owner.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- States: IDLE, SEND, WAIT.
- IDLE:
  - The winner is the first index with `req_valid` set, searching upward from `rr_ptr` and wrapping modulo `NUM_REQ`.
  - If any `req_valid` is set, register the winner into `grant_id`, clear the hold counter, and go to SEND.
  - If no `req_valid` is set, stay in IDLE.
- SEND:
  - `req_ready[grant_id]` equals `req_valid[grant_id]`; this is combinational from state and the valid input.
  - On acceptance: capture the byte into `tx_data`, capture `req_last` into `last_q`, assert `tx_start` (registered) for the next cycle, and go to WAIT.
  - While the granted source has `req_valid` low, the hold counter increments.
  - When the counter reaches `HOLD_CYCLES-1`, release: set `rr_ptr` to `grant_id+1` (mod `NUM_REQ`) and go to IDLE. The remainder of that message is dropped by the arbiter; the source retries.
  - Other sources' `req_valid` is ignored, and their `req_ready` stays 0.
- WAIT:
  - `tx_start` is high in the first WAIT cycle only.
  - `tx_done` is ignored in the cycle `tx_start` is high.
  - On `tx_done` with `last_q`=1: set `rr_ptr` to `grant_id+1` and go to IDLE.
  - On `tx_done` with `last_q`=0: clear the hold counter and go to SEND.
- Requesters must hold `req_valid`, `req_data` and `req_last` stable until `req_ready` is asserted.
- Arithmetic:
  - `rr_ptr` and `grant_id` wrap modulo `NUM_REQ`, including non-power-of-two values.
  - The hold counter is `$clog2(HOLD_CYCLES+1)` bits wide and saturates; it never wraps.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State returns to IDLE.
  - `rr_ptr`, `grant_id`, `tx_data` and the hold counter are all 0.
  - `tx_start`, `busy` and `req_ready` are all 0.
  - Any in-flight byte is abandoned, and a late `tx_done` is ignored.
- Latency from a valid request in IDLE:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: in SEND; `req_ready` high.
  - Cycle 2: `tx_start` high.
  - This gives 2 cycles from request to `tx_start`.
- Turnaround from `tx_done` within a message:
  - Cycle 0: `tx_done`.
  - Cycle 1: `req_ready`, if the source's valid is already high.
  - Cycle 2: `tx_start`.
- Turnaround from `tx_done` on the last byte: 1 cycle in IDLE, then 1 cycle to the next grant.
- Simultaneous events:
  - `req_valid` rising on several sources in the same cycle: resolved by `rr_ptr` alone.
  - `tx_done` while in SEND or IDLE: ignored.
  - The hold timeout expiring in the same cycle `req_valid` rises: acceptance wins.
- `busy` is registered with the state and falls in the first IDLE cycle.

## Structure
- Shared package `uart_pkg`:
  - `state_t` enum (IDLE, SEND, WAIT).
  - `DATA_BITS_DEFAULT` = 8.
  - Helper function `rr_next(ptr, n)`.
- Sub-module `rr_pick`: purely combinational. Takes the `req_valid` vector and `rr_ptr`; outputs the winner index and an `any` flag. It is reusable for a future RX-side dispatcher.
- Top level: the FSM, the hold counter, and the `tx_data`, `last_q` and `grant_id` registers.

## Test plan
- **Single 1-byte message.** Source 2 offers 0x5A with `last`=1 after reset; `tx_done` is pulsed 10 cycles after `tx_start`. Required: exactly 1 `tx_start` with `tx_data`=0x5A, `grant_id`=2, back to IDLE, `rr_ptr`=3.
- **Round-robin fairness.** Sources 0, 1 and 3 each offer one-byte messages continuously. Required: grant order 0, 1, 3, 0, 1, 3; source 2 is never granted.
- **Message atomicity.** Source 1 sends 0x11, 0x22, 0x33 (`last` on 0x33) while source 0 is always valid. Required: the three bytes go out consecutively, and source 0 is granted only after 0x33's `tx_done`.
- **Hold timeout.** With `HOLD_CYCLES`=8, source 0 sends 0xA0 (`last`=0) and then drops valid. Required: release to IDLE exactly 8 cycles after entering SEND; the next grant goes to source 1 if it is valid.
- **Reset mid-byte.** Assert `reset` low in the WAIT state after `tx_start`. Required: `tx_start`, `busy` and `req_ready` are all 0 immediately; a `tx_done` arriving after reset deasserts causes no grant or state change.
- **`NUM_REQ`=3 wrap.** Make the grant of index 2 finish. Required: `rr_ptr`=0, and the next contention between sources 0 and 2 goes to 0.
